// File: rtl/data_memory_arbiter.sv
// Two-port round-robin arbiter in front of data_memory_wrapper, with bus lock for atomic RMW.
// Define MEM_ARB_PERF_CNT_EN to add saturating per-port grant and stall counters.
module data_memory_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_wrt,
  input  logic              r0_lock,
  input  logic [1:0]        r0_width,
  input  logic              r0_unsigned,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wrt_data,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rd_data,
  input  logic              r1_req,
  input  logic              r1_wrt,
  input  logic              r1_lock,
  input  logic [1:0]        r1_width,
  input  logic              r1_unsigned,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wrt_data,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rd_data,
  output logic              mem_rd_en,
  output logic              mem_wrt_en,
  output logic [1:0]        mem_width,
  output logic              mem_unsigned,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wrt_data,
  input  logic [DATA_W-1:0] mem_rd_data
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_gnt0,
  output logic [31:0]       perf_gnt1,
  output logic [31:0]       perf_stall0,
  output logic [31:0]       perf_stall1
`endif
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {ARB = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_e;

  typedef struct packed {
    logic [1:0]        width;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } fields_t;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvld_q, rvld_d;
  logic             rtag_q, rtag_d;
  fields_t          hold_q, hold_d;
  fields_t          f0, f1, win;
  logic             gnt0, gnt1, any_gnt, win_wrt, lock_full;

  assign f0        = {r0_width, r0_unsigned, r0_addr, r0_wrt_data};
  assign f1        = {r1_width, r1_unsigned, r1_addr, r1_wrt_data};
  assign lock_full = (cnt_q >= CNT_W'(LOCK_MAX - 1));

  // Grant selection, pointer update and lock FSM
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      ARB: begin
        gnt0 = r0_req & (~r1_req | ~ptr_q);
        gnt1 = r1_req & ~gnt0;
      end
      LOCK0:   gnt0 = r0_req;
      LOCK1:   gnt1 = r1_req;
      default: ;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
    case (state_q)
      ARB: begin
        if (gnt0 && r0_lock) begin
          state_d = LOCK0;
          cnt_d   = CNT_W'(1);
        end else if (gnt1 && r1_lock) begin
          state_d = LOCK1;
          cnt_d   = CNT_W'(1);
        end
      end
      LOCK0: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((gnt0 && !r0_lock) || (!r0_req && !r0_lock)) begin
          state_d = ARB;
          cnt_d   = '0;
        end else if (lock_full) begin
          // Forced release hands priority to the starved port
          state_d = ARB;
          cnt_d   = '0;
          ptr_d   = 1'b1;
        end
      end
      LOCK1: begin
        cnt_d = cnt_q + CNT_W'(1);
        if ((gnt1 && !r1_lock) || (!r1_req && !r1_lock)) begin
          state_d = ARB;
          cnt_d   = '0;
        end else if (lock_full) begin
          state_d = ARB;
          cnt_d   = '0;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Issue path: winner's fields this cycle, otherwise the last issued fields
  always_comb begin
    any_gnt = gnt0 | gnt1;
    win     = gnt1 ? f1 : f0;
    win_wrt = gnt1 ? r1_wrt : r0_wrt;
    hold_d  = any_gnt ? win : hold_q;
    rvld_d  = (gnt0 & ~r0_wrt) | (gnt1 & ~r1_wrt);
    rtag_d  = gnt1;
  end

  assign r0_gnt       = gnt0;
  assign r1_gnt       = gnt1;
  assign mem_rd_en    = any_gnt & ~win_wrt;
  assign mem_wrt_en   = any_gnt & win_wrt;
  assign mem_width    = hold_d.width;
  assign mem_unsigned = hold_d.uns;
  assign mem_addr     = hold_d.addr;
  assign mem_wrt_data = hold_d.data;

  // Read return routed by the tag of the previous cycle's read grant
  assign r0_rvalid  = rvld_q & ~rtag_q & ~rst;
  assign r1_rvalid  = rvld_q & rtag_q & ~rst;
  assign r0_rd_data = r0_rvalid ? mem_rd_data : '0;
  assign r1_rd_data = r1_rvalid ? mem_rd_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
      rtag_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rvld_q  <= rvld_d;
      rtag_q  <= rtag_d;
      hold_q  <= hold_d;
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  // Saturating grant and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0   <= '0;
      perf_gnt1   <= '0;
      perf_stall0 <= '0;
      perf_stall1 <= '0;
    end else begin
      if (gnt0 && (perf_gnt0 != '1)) perf_gnt0 <= perf_gnt0 + 32'd1;
      if (gnt1 && (perf_gnt1 != '1)) perf_gnt1 <= perf_gnt1 + 32'd1;
      if (r0_req && !gnt0 && (perf_stall0 != '1)) perf_stall0 <= perf_stall0 + 32'd1;
      if (r1_req && !gnt1 && (perf_stall1 != '1)) perf_stall1 <= perf_stall1 + 32'd1;
    end
  end
`else
  // Default build carries no counter logic.
`endif

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Shares the single data_memory_wrapper port between two requesters: port 0 (CPU load/store stage) and port 1 (DMA / graphics engine).
- Round-robin arbitration with a one-cycle read-return pipeline.
- Optional bus lock lets a requester perform atomic read-modify-write sequences.
- Sits between the requesters and data_memory_wrapper, and drives all wrapper control and data pins.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LOCK_MAX, 8, maximum consecutive cycles a requester may hold the lock before it is forcibly released.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rN_req  in  1  request from port N (N = 0, 1); held with its fields until granted.
- rN_wrt  in  1  1 = write, 0 = read.
- rN_lock  in  1  request to keep ownership after this grant.
- rN_width  in  2  access width, passed through to the wrapper (00 word, 01 halfword, 10 byte).
- rN_unsigned  in  1  zero-extend on read.
- rN_addr  in  ADDR_W  address.
- rN_wrt_data  in  DATA_W  write data.
- rN_gnt  out  1  combinational grant; the transaction is issued this cycle.
- rN_rvalid  out  1  read data valid, one cycle after a read grant.
- rN_rd_data  out  DATA_W  read data; valid only while rN_rvalid is high.
- mem_rd_en  out  1  wrapper read enable.
- mem_wrt_en  out  1  wrapper write enable.
- mem_width  out  2  wrapper width.
- mem_unsigned  out  1  wrapper sign control.
- mem_addr  out  ADDR_W  wrapper address.
- mem_wrt_data  out  DATA_W  wrapper write data.
- mem_rd_data  in  DATA_W  wrapper read data, valid the cycle after mem_rd_en.

Behaviour:
- Reset values: all gnt and rvalid outputs 0; mem_rd_en and mem_wrt_en 0; mem_* data and address fields 0; FSM = ARB; priority pointer = port 0; lock counter = 0.
- Throughput: one transaction issued per cycle maximum. Back-to-back grants are allowed, including read followed by read and read followed by write.
- Grant rules in state ARB:
  - Only one requesting: that port wins.
  - Both requesting: the port the priority pointer names wins.
  - After any grant, the pointer moves to the other port.
- Issue: in the grant cycle, the winner's fields drive mem_*. mem_rd_en = ~wrt and mem_wrt_en = wrt, both asserted only in the grant cycle.
- No requests: mem_rd_en and mem_wrt_en are 0; mem_addr, mem_width and mem_wrt_data hold their last values.
- Read return:
  - A registered tag records the port of each read grant.
  - The next cycle, that port's rvalid = 1 and its rd_data = mem_rd_data.
  - The other port's rvalid = 0 and its rd_data = 0.
  - Total read latency is 1 cycle from gnt.
- FSM states: ARB, LOCK0, LOCK1.
  - ARB → LOCKn when port n is granted with rn_lock = 1; the lock counter loads 1.
  - In LOCKn, only port n can be granted; the other port's gnt is forced to 0.
  - Each LOCKn cycle increments the counter.
  - LOCKn → ARB when rn_lock = 0 on a grant cycle, when rn_req = 0 and rn_lock = 0, or when the counter reaches LOCK_MAX.
  - Forced release at LOCK_MAX: the pointer points to the other port. That port wins next if it is requesting.
- Simultaneous read return and new grant: independent. The rvalid of a previous read and a new gnt may coincide on the same or different ports.
- Reset mid-operation: a pending rvalid is dropped (no rvalid the cycle after reset); the lock is cleared.
- Address and width alignment are not checked; they are passed through unchanged.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_gnt0, perf_gnt1, perf_stall0 and perf_stall1, each 32 bits.
  - perf_gntN counts grants to port N.
  - perf_stallN counts cycles in which rN_req = 1 and rN_gnt = 0.
  - All counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: no counter ports and no counter logic.

Test Plan:
- Single read: r0 reads addr 0x0, width 10, signed, with memory holding 0x8F → r0_gnt the same cycle; r0_rvalid the next cycle with r0_rd_data = 0xFFFFFF8F; r1_rvalid stays 0.
- Contention: both ports request from reset (r0 write of 0xDEADBEEF to 0x2, r1 read of 0x2) → cycle 0 grants r0; cycle 1 grants r1; r1_rd_data = 0xDEADBEEF in cycle 2.
- Fairness: both ports hold req for 6 cycles → grants alternate 0,1,0,1,0,1; each port's stall never exceeds 1 cycle.
- Lock: r1 reads 0x1 with lock, then writes 0x1 with lock = 0, while r0 requests continuously → r0_gnt = 0 for both r1 cycles; r0 is granted the cycle after the r1 write.
- Lock timeout: r0 holds lock and req for 12 cycles with LOCK_MAX = 8, while r1 requests → r0 is granted 8 consecutive times, then r1 is granted in the next cycle.
- Reset mid-read: rst asserted in the cycle after a read grant → rvalid = 0, FSM = ARB and pointer = port 0 on the following cycle. With MEM_ARB_PERF_CNT_EN defined, all counters = 0.
